// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared state encoding, counter sizing and parameter legality
//               helpers for the camera-pipeline reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

  // Encodings are visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int c_STATE_W = 2;
  localparam int c_LLC_W   = 8;

  // Width shared by the stability and stagger counters.
  function automatic int cnt_width(input int lock_stable, input int stagger);
    int m;
    m = (lock_stable > stagger) ? lock_stable : stagger;
    return $clog2(m + 1);
  endfunction

  // True when every parameter is inside its legal range.
  function automatic bit params_legal(input int n_ch, input int sync_stages,
                                      input int lock_stable, input int stagger);
    return (n_ch >= 1) && (sync_stages >= 2) && (lock_stable >= 1) && (stagger >= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : Single-bit multi-flop synchroniser with synchronous
//               active-low reset; all stages reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic pclk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Holds all reset channels until PLL lock has been stable for
//               LOCK_STABLE cycles, then releases channels in ascending order
//               every STAGGER cycles. Lock loss or sw_rst re-asserts all.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 16,
  parameter int STAGGER     = 8
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic                 locked,
  input  logic                 sw_rst,
  output logic [N_CH-1:0]      rst_out,
  output logic                 all_released,
  output logic [c_STATE_W-1:0] state,
  output logic [c_LLC_W-1:0]   lock_lost_cnt
);

  localparam int c_CNT_W = cnt_width(LOCK_STABLE, STAGGER);
  localparam int c_CH_W  = $clog2(N_CH + 1);

  localparam logic [c_CNT_W-1:0] c_STAB_LAST = c_CNT_W'(LOCK_STABLE - 1);
  localparam logic [c_CNT_W-1:0] c_STAG_LAST = c_CNT_W'(STAGGER - 1);
  localparam logic [c_CH_W-1:0]  c_CH_LAST   = c_CH_W'(N_CH - 1);

  // Reject illegal parameter sets at elaboration.
  if (!params_legal(N_CH, SYNC_STAGES, LOCK_STABLE, STAGGER)) begin : g_param_check
    $error("reset_sequencer: illegal parameter set");
  end

  logic                 w_locked_s;

  state_e               r_state,     w_state_nxt;
  logic [c_CNT_W-1:0]   r_stab_cnt,  w_stab_nxt;
  logic [c_CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic [c_CH_W-1:0]    r_ch,        w_ch_nxt;
  logic [N_CH-1:0]      r_rst,       w_rst_nxt;
  logic                 r_all_rel,   w_all_rel_nxt;
  logic [c_LLC_W-1:0]   r_llc,       w_llc_nxt;
  logic                 w_lock_loss;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_locked_sync (
    .pclk    (pclk),
    .reset_n (reset_n),
    .i_d     (locked),
    .o_q     (w_locked_s)
  );

  // Lock loss is only an event once release has begun.
  assign w_lock_loss = (r_state != ST_HOLD) && !w_locked_s;

  // Next-state, counter and output-register decode.
  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab_cnt;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_rst_nxt   = r_rst;
    w_llc_nxt   = r_llc;

    if (w_lock_loss) begin
      // A simultaneous sw_rst is folded into this single lock-loss event.
      w_state_nxt = ST_HOLD;
      w_stab_nxt  = '0;
      w_cnt_nxt   = '0;
      w_ch_nxt    = '0;
      w_rst_nxt   = '1;
      if (r_llc != {c_LLC_W{1'b1}}) begin
        w_llc_nxt = r_llc + 1'b1;
      end
    end else if (sw_rst) begin
      w_state_nxt = ST_HOLD;
      w_stab_nxt  = '0;
      w_cnt_nxt   = '0;
      w_ch_nxt    = '0;
      w_rst_nxt   = '1;
    end else begin
      case (r_state)
        ST_HOLD: begin
          w_rst_nxt = '1;
          if (w_locked_s) begin
            if (r_stab_cnt == c_STAB_LAST) begin
              w_state_nxt = ST_RELEASE;
              w_stab_nxt  = '0;
              w_cnt_nxt   = '0;
              w_ch_nxt    = '0;
            end else begin
              w_stab_nxt = r_stab_cnt + 1'b1;
            end
          end else begin
            w_stab_nxt = '0;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == c_STAG_LAST) begin
            w_cnt_nxt = '0;
            // Only the current channel is cleared; earlier bits already hold 0.
            for (int i = 0; i < N_CH; i++) begin
              if (r_ch == c_CH_W'(i)) begin
                w_rst_nxt[i] = 1'b0;
              end
            end
            w_ch_nxt = r_ch + 1'b1;
            if (r_ch == c_CH_LAST) begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          w_rst_nxt = '0;
        end
        default: begin
          w_state_nxt = ST_HOLD;
          w_rst_nxt   = '1;
        end
      endcase
    end

    w_all_rel_nxt = (w_rst_nxt == '0);
  end

  // State, counters and registered outputs.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      r_state    <= ST_HOLD;
      r_stab_cnt <= '0;
      r_cnt      <= '0;
      r_ch       <= '0;
      r_rst      <= '1;
      r_all_rel  <= 1'b0;
      r_llc      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ch       <= w_ch_nxt;
      r_rst      <= w_rst_nxt;
      r_all_rel  <= w_all_rel_nxt;
      r_llc      <= w_llc_nxt;
    end
  end

  assign rst_out       = r_rst;
  assign all_released  = r_all_rel;
  assign state         = r_state;
  assign lock_lost_cnt = r_llc;

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset generator for the camera pipeline. It sits between the clock-wizard `locked` output and the downstream blocks: capture, FIFO, VGA and SCCB. It holds all reset channels asserted until the PLL lock has been stable for a programmable time, then releases the channels one by one in index order with a programmable stagger. It re-asserts every channel on lock loss or on a software request.

## Interface
- `N_CH`, default 4: number of reset output channels, ≥1.
- `SYNC_STAGES`, default 2: synchroniser depth for `locked`, ≥2.
- `LOCK_STABLE`, default 16: consecutive synchronised-locked cycles required before release starts, ≥1.
- `STAGGER`, default 8: cycles between successive channel releases, ≥1.
- `pclk`  in  1  sole clock; every flop is clocked on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low; highest priority.
- `locked`  in  1  PLL lock, asynchronous to `pclk`.
- `sw_rst`  in  1  synchronous software reset request, level-sensitive.
- `rst_out`  out  N_CH  active-high per-channel reset, registered.
- `all_released`  out  1  high when every `rst_out` bit is 0, registered.
- `state`  out  2  current FSM state: HOLD=0, RELEASE=1, RUN=2.
- `lock_lost_cnt`  out  8  count of lock-loss events; saturates at 255.

## Operation
- `locked` passes through a `SYNC_STAGES` flop chain; its output is `locked_s`. The core logic never samples raw `locked`.
- **HOLD**
  - `rst_out` is all ones.
  - `stab_cnt` increments while `locked_s`=1 and `sw_rst`=0; it clears to 0 otherwise.
  - When `stab_cnt`==`LOCK_STABLE`-1 and `locked_s`=1, go to RELEASE with `ch`=0 and `cnt`=0.
- **RELEASE**
  - `cnt` increments each cycle.
  - When `cnt`==`STAGGER`-1: clear `rst_out[ch]`, clear `cnt`, and increment `ch`.
  - After clearing bit `N_CH`-1, go to RUN.
  - Channels only ever release in ascending index order. Bits already released stay 0.
- **RUN**: `rst_out` is all zeros and `all_released`=1.
- **Lock loss**: `locked_s`=0 in RELEASE or RUN. On the next edge, `rst_out` goes to all ones, `all_released`=0, state goes to HOLD, counters clear, and `lock_lost_cnt` increments by 1 (saturating).
- **Software reset**: `sw_rst`=1 in any state gives the same response as lock loss, except `lock_lost_cnt` is not changed. The FSM stays in HOLD while `sw_rst` is held.
- **Priority**: `reset_n`=0, then lock loss, then `sw_rst`, then normal progression. If lock loss and `sw_rst` occur in the same cycle, it counts as one lock-loss event.
- **`lock_lost_cnt`** is cleared only by `reset_n`.
- **Counter widths**: `stab_cnt` and `cnt` are `$clog2(max(LOCK_STABLE,STAGGER)+1)` bits. `ch` is `$clog2(N_CH+1)` bits. No counter wraps.

## Timing
- **Reset values** (`reset_n`=0 sampled): `rst_out`=all ones, `all_released`=0, `state`=HOLD, `lock_lost_cnt`=0, synchroniser flops=0, all counters=0.
- **Release latency**: count edge 1 as the first edge that samples `locked`=1, with `sw_rst`=0 throughout.
  - `locked_s` rises after `SYNC_STAGES` edges.
  - `rst_out[k]` falls at edge `SYNC_STAGES`+`LOCK_STABLE`+(k+1)·`STAGGER`.
  - With defaults: ch0 falls at edge 26, ch3 at edge 50, and `all_released` rises at edge 50.
- **Assert latency**: after `locked` falls, all `rst_out` go high `SYNC_STAGES`+1 edges later. Assertion is synchronous by design.
- **Glitches**: a `locked` low glitch shorter than one cycle that is still captured by the synchroniser counts as a full loss.
- **Mid-release abort**: a lock drop during RELEASE re-asserts channels that were already released. The stagger restarts from ch0 after the next full `LOCK_STABLE` window.
- **`reset_n` mid-operation**: the reset values apply on the next edge regardless of state.

## Structure
- Shared package `reset_seq_pkg` holds the state encodings HOLD/RELEASE/RUN and the parameter-legality checks, as an elaboration-time error for illegal values.
- Sub-module `bit_sync`: a `SYNC_STAGES`-deep flop chain with synchronous active-low `reset_n`, reset value 0, reusable elsewhere.
- The top level contains the FSM, the counters, and the `rst_out`, `all_released` and `lock_lost_cnt` registers.

## Test plan
- **Power-up**: `reset_n`=0 for 5 cycles, `locked`=0 → `rst_out`=4'b1111, `state`=0, `lock_lost_cnt`=0. Release `reset_n` and keep `locked`=0 → no change after 100 cycles.
- **Nominal release**: raise `locked` with defaults → `rst_out` goes 1110 at edge 26, 1100 at 34, 1000 at 42, 0000 at 50. `all_released`=1 and `state`=2 at edge 50.
- **Unstable lock**: toggle `locked` high 10 cycles, low 1 cycle, repeatedly → `state` never leaves 0 and `rst_out` stays 1111.
- **Lock loss in RUN and mid-RELEASE**: drop `locked` after full release → 1111 at 3 edges later and `lock_lost_cnt`=1. Drop it again when `rst_out`=1100 → 1111 and `lock_lost_cnt`=2. Re-lock → full sequence repeats from ch0.
- **Software reset**: pulse `sw_rst` 1 cycle in RUN → `rst_out`=1111 on next edge and `lock_lost_cnt` unchanged. Release completes 16+8·4 edges after `sw_rst` drops.
- **Saturation and parameter sweep**: 300 lock losses → `lock_lost_cnt`=255. Re-run the nominal release with `N_CH`=1, `STAGGER`=1, `LOCK_STABLE`=1, `SYNC_STAGES`=3 → ch0 falls at edge 5.
